// File: rtl/io_poll_if.sv
// CPU-side request/response and IO-bus signals of the polling bus master.
// master = the bus initiator; slave = CPU requester plus IO peripheral.
interface io_poll_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (
        input  req_valid, req_op, req_wdata, io_din,
        output req_ready, resp_valid, resp_data, resp_timeout,
        output io_addr, io_dout, io_we, io_rd
    );

    modport slave (
        output req_valid, req_op, req_wdata, io_din,
        input  req_ready, resp_valid, resp_data, resp_timeout,
        input  io_addr, io_dout, io_we, io_rd
    );
endinterface

// File: rtl/io_poll_master.sv
// IO bus initiator: switch read, LED write, and flag-polled read/write. Response 2 cycles after accept
// (3 for polled ops ready on first poll, +1+POLL_GAP per extra poll); req_ready is low while busy.
module io_poll_master #(
    parameter logic [7:0] ADDR_SW          = 8'h08,
    parameter logic [7:0] ADDR_LED         = 8'h0C,
    parameter logic [7:0] ADDR_POL_IN_VLD  = 8'h10,
    parameter logic [7:0] ADDR_POL_IN      = 8'h14,
    parameter logic [7:0] ADDR_POL_OUT_VLD = 8'h18,
    parameter logic [7:0] ADDR_POL_OUT     = 8'h1C,
    parameter int         POLL_GAP         = 4,
    parameter int         TIMEOUT          = 1024
) (
    input logic       clk,
    input logic       rstn,
    io_poll_if.master bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [CW-1:0] TO_C     = CW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_SIMPLE, S_POLL, S_GAP, S_XFER, S_RESP} state_t;

    state_t        state, state_n;
    logic [1:0]    op, op_n;
    logic [31:0]   wdata, wdata_n;
    logic [CW-1:0] poll_cnt, poll_n, poll_inc;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [31:0]   resp_data_n, io_dout_n;
    logic          resp_to_n, io_we_n, io_rd_n, flag_ok;
    logic [7:0]    io_addr_n;

    always_comb begin
        state_n     = state;
        op_n        = op;
        wdata_n     = wdata;
        poll_n      = poll_cnt;
        gap_n       = gap_cnt;
        resp_data_n = bus.resp_data;
        resp_to_n   = bus.resp_timeout;
        // saturates so TIMEOUT=0 can poll indefinitely
        poll_inc    = (poll_cnt == '1) ? poll_cnt : poll_cnt + CW'(1);
        // op[0]=1 waits for the busy flag to clear, op[0]=0 for the valid flag to set
        flag_ok     = op[0] ? ~bus.io_din[0] : bus.io_din[0];

        case (state)
            S_IDLE: if (bus.req_valid) begin
                op_n    = bus.req_op;
                wdata_n = bus.req_wdata;
                poll_n  = '0;
                state_n = bus.req_op[1] ? S_POLL : S_SIMPLE;
            end
            S_SIMPLE, S_XFER: begin
                resp_data_n = op[0] ? 32'd0 : bus.io_din;
                resp_to_n   = 1'b0;
                state_n     = S_RESP;
            end
            S_POLL: begin
                poll_n = poll_inc;
                if (flag_ok) begin
                    state_n = S_XFER;
                end else if ((TIMEOUT != 0) && (poll_inc == TO_C)) begin
                    resp_data_n = 32'd0;
                    resp_to_n   = 1'b1;
                    state_n     = S_RESP;
                end else if (POLL_GAP == 0) begin
                    state_n = S_POLL;
                end else begin
                    gap_n   = '0;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_POLL;
                else                     gap_n   = gap_cnt + GW'(1);
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // outputs are registered, so decode them from the state about to be entered
        io_addr_n = 8'h00;
        io_dout_n = 32'd0;
        io_we_n   = 1'b0;
        io_rd_n   = 1'b0;
        case (state_n)
            S_SIMPLE: if (op_n[0]) begin
                io_addr_n = ADDR_LED;
                io_dout_n = wdata_n;
                io_we_n   = 1'b1;
            end else begin
                io_addr_n = ADDR_SW;
            end
            S_POLL: io_addr_n = op_n[0] ? ADDR_POL_OUT_VLD : ADDR_POL_IN_VLD;
            S_XFER: if (op_n[0]) begin
                io_addr_n = ADDR_POL_OUT;
                io_dout_n = wdata_n;
                io_we_n   = 1'b1;
            end else begin
                io_addr_n = ADDR_POL_IN;
                io_rd_n   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= S_IDLE;
            op               <= 2'b00;
            wdata            <= 32'd0;
            poll_cnt         <= '0;
            gap_cnt          <= '0;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= 32'd0;
            bus.resp_timeout <= 1'b0;
            bus.io_addr      <= 8'h00;
            bus.io_dout      <= 32'd0;
            bus.io_we        <= 1'b0;
            bus.io_rd        <= 1'b0;
        end else begin
            state            <= state_n;
            op               <= op_n;
            wdata            <= wdata_n;
            poll_cnt         <= poll_n;
            gap_cnt          <= gap_n;
            bus.req_ready    <= (state_n == S_IDLE);
            bus.resp_valid   <= (state_n == S_RESP);
            bus.resp_data    <= resp_data_n;
            bus.resp_timeout <= resp_to_n;
            bus.io_addr      <= io_addr_n;
            bus.io_dout      <= io_dout_n;
            bus.io_we        <= io_we_n;
            bus.io_rd        <= io_rd_n;
        end
    end
endmodule

// File: tb/tb_io_poll_master.sv
// Bench for io_poll_master: a peripheral model with scripted flag sequences plus a
// transaction-level reference (poll count, latency, strobes, response) for each request.
module tb_io_poll_master;
    localparam int GAP = 4;
    localparam int TO  = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    io_poll_if bus ();

    io_poll_master #(.POLL_GAP(GAP), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // peripheral: flag reports "not ready" for the first k_busy polls of a transaction
    logic [31:0] sw_val = 32'd0, pin_val = 32'd0, junk = 32'd0;
    int k_busy = 0, dev_base = 0, dev_polls = 0, cyc = 0;
    logic nr;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.io_addr == 8'h10 || bus.io_addr == 8'h18) dev_polls <= dev_polls + 1;
    end

    always_comb begin
        nr = (dev_polls - dev_base) < k_busy;
        case (bus.io_addr)
            8'h08:   bus.io_din = sw_val;
            8'h10:   bus.io_din = {junk[31:1], ~nr};
            8'h18:   bus.io_din = {junk[31:1], nr};
            8'h14:   bus.io_din = pin_val;
            default: bus.io_din = junk;
        endcase
    end

    // bus monitor, sampled mid-cycle
    int we_cnt = 0, rd_cnt = 0, both_cnt = 0, poll_seen = 0, resp_cnt = 0;
    logic [7:0]  we_addr = 8'h00, rd_addr = 8'h00;
    logic [31:0] we_dout = 32'd0;

    always @(negedge clk) begin
        if (bus.io_we) begin we_cnt++; we_addr = bus.io_addr; we_dout = bus.io_dout; end
        if (bus.io_rd) begin rd_cnt++; rd_addr = bus.io_addr; end
        if (bus.io_we && bus.io_rd) both_cnt++;
        if (bus.io_addr == 8'h10 || bus.io_addr == 8'h18) poll_seen++;
        if (bus.resp_valid) resp_cnt++;
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] wd, input int k,
                         input logic [31:0] sw, input logic [31:0] pin, output int c0);
        logic rdy_seen;
        rdy_seen = 1'b0;
        for (int i = 0; i < 20 && !rdy_seen; i++) begin
            if (bus.req_ready) rdy_seen = 1'b1;
            else @(negedge clk);
        end
        check("req_ready_wait", {31'd0, rdy_seen}, 32'd1);
        sw_val        = sw;
        pin_val       = pin;
        junk          = $urandom;
        k_busy        = k;
        dev_base      = dev_polls;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wdata = wd;
        c0            = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_wdata = $urandom;
    endtask

    task automatic txn(input logic [1:0] op, input logic [31:0] wd, input int k,
                       input logic [31:0] sw, input logic [31:0] pin);
        int we0, rd0, pl0, bo0, c0, lat, e_polls, e_lat, e_we, e_rd;
        logic e_to, seen;
        logic [31:0] e_data;

        // reference: outcome of the request from the request rules alone
        if (!op[1]) begin
            e_polls = 0; e_to = 1'b0; e_lat = 2;
        end else if (k >= TO) begin
            e_polls = TO; e_to = 1'b1; e_lat = 2 + (TO - 1) * (GAP + 1);
        end else begin
            e_polls = k + 1; e_to = 1'b0; e_lat = 3 + k * (GAP + 1);
        end
        e_we   = (op[0] && !e_to) ? 1 : 0;
        e_rd   = (op == 2'b10 && !e_to) ? 1 : 0;
        e_data = (op == 2'b00) ? sw : (op == 2'b10 && !e_to) ? pin : 32'd0;

        we0 = we_cnt; rd0 = rd_cnt; pl0 = poll_seen; bo0 = both_cnt;
        issue(op, wd, k, sw, pin, c0);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.resp_valid) begin seen = 1'b1; lat = cyc - c0; end
            else @(negedge clk);
        end
        check("resp_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, e_lat);
        check("resp_data", bus.resp_data, e_data);
        check("resp_timeout", {31'd0, bus.resp_timeout}, {31'd0, e_to});
        check("we_count", we_cnt - we0, e_we);
        check("rd_count", rd_cnt - rd0, e_rd);
        check("poll_count", poll_seen - pl0, e_polls);
        check("we_rd_overlap", both_cnt - bo0, 0);
        if (e_we == 1) begin
            check("we_addr", {24'd0, we_addr}, op[1] ? 32'h1C : 32'h0C);
            check("we_dout", we_dout, wd);
        end
        if (e_rd == 1) check("rd_addr", {24'd0, rd_addr}, 32'h14);
        @(negedge clk);
        check("resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
        check("ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("resp_hold", bus.resp_data, e_data);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_timeout", {31'd0, bus.resp_timeout}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_io_addr", {24'd0, bus.io_addr}, 32'd0);
        check("rst_io_dout", bus.io_dout, 32'd0);
        check("rst_io_we", {31'd0, bus.io_we}, 32'd0);
        check("rst_io_rd", {31'd0, bus.io_rd}, 32'd0);
    endtask

    initial begin
        int c0, we0, rs0, pl0;
        logic in_gap;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_wdata = 32'd0;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        txn(2'b00, 32'd0, 0, 32'h0000_A5A5, 32'd0);
        txn(2'b10, 32'd0, 3, 32'd0, 32'h0000_1234);
        txn(2'b11, 32'hDEAD_BEEF, 2, 32'd0, 32'd0);
        txn(2'b10, 32'd0, 1000, 32'd0, 32'h5555_AAAA);
        txn(2'b01, 32'hCAFE_F00D, 0, 32'd0, 32'd0);

        // reset while a polled write sits in its gap: no write, no response
        we0 = we_cnt; rs0 = resp_cnt; pl0 = poll_seen;
        issue(2'b11, 32'h0BAD_0BAD, 6, 32'd0, 32'd0, c0);
        in_gap = 1'b0;
        for (int i = 0; i < 50 && !in_gap; i++) begin
            if (poll_seen > pl0 && bus.io_addr == 8'h00) in_gap = 1'b1;
            else @(negedge clk);
        end
        check("gap_reached", {31'd0, in_gap}, 32'd1);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_we", we_cnt - we0, 0);
        check("abort_no_resp", resp_cnt - rs0, 0);
        txn(2'b01, 32'h0000_00F1, 0, 32'd0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            txn(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 10), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
